snn_seq_ctrl: RTL

- Top-level sequencer for the SNN datapath: UART receiver -> 784x1 input RAM -> snn_core -> UART transmitter.
- Accepts one 98-byte image frame from the UART receiver and unpacks each byte into single-bit writes to the input RAM.
- Pulses snn_core start, waits for done, then sends the ASCII result through the transmitter.
- Rejects and flags bytes that arrive while a classification is in flight.

---
 rtl/snn_seq_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/snn_seq_ctrl.sv
// snn_seq_ctrl: frame sequencer for the SNN datapath.
// UART RX bytes are unpacked LSB-first into the 784x1 input RAM, snn_core is
// started and its digit is sent back as ASCII over UART TX.
// Optional core watchdog: define SNN_SEQ_CTRL_TIMEOUT_EN.
module snn_seq_ctrl #(
    parameter int unsigned NUM_BYTES      = 98,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [3:0]        result,
    output logic              err_ovr,
    output logic              err_tmo
);

    localparam int unsigned BC_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        RX_WAIT,
        UNPACK,
        START,
        COMPUTE,
        TX_WAIT,
        TX_SEND
    } state_t;

    state_t          state;
    logic [BC_W-1:0] byte_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic [7:0]      hold_q;
    logic            hold_full;

    logic [BC_W-1:0] byte_cnt_inc;
    logic            last_byte;
    logic [7:0]      load_byte;

`ifdef SNN_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    // Watchdog limit has no meaning without the watchdog.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign err_tmo        = 1'b0;
`endif

    // Byte bookkeeping shared by the unpack transitions.
    assign byte_cnt_inc = byte_cnt + BC_W'(1);
    assign last_byte    = (byte_cnt_inc == BC_W'(NUM_BYTES));
    assign load_byte    = hold_full ? hold_q : rx_data;

    // First RAM address of a byte: byte index times eight.
    function automatic logic [ADDR_W-1:0] base_addr(input logic [BC_W-1:0] b);
        return ADDR_W'(b) << 3;
    endfunction

    // Digits 0..9 map to ASCII '0'..'9', anything else to '?'.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end
        return 8'h3F;
    endfunction

    // Sequencer: state, counters, hold register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_WAIT;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_d      <= 1'b0;
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            result     <= '0;
            err_ovr    <= 1'b0;
`ifdef SNN_SEQ_CTRL_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_tmo    <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;

            // Bytes arriving while a classification is in flight are lost.
            if (rx_rdy && (state inside {START, COMPUTE, TX_WAIT, TX_SEND})) begin
                err_ovr <= 1'b1;
            end

            case (state)
                RX_WAIT: begin
                    if (rx_rdy) begin
                        state    <= UNPACK;
                        busy     <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_d    <= load_byte[0];
                        ram_addr <= base_addr(byte_cnt);
                        shift_q  <= {1'b0, load_byte[7:1]};
                        bit_cnt  <= '0;
                    end
                end

                UNPACK: begin
                    if (bit_cnt != 3'd7) begin
                        ram_we   <= 1'b1;
                        ram_d    <= shift_q[0];
                        ram_addr <= ram_addr + ADDR_W'(1);
                        shift_q  <= {1'b0, shift_q[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (rx_rdy) begin
                            if (hold_full) begin
                                err_ovr <= 1'b1;
                            end else begin
                                hold_q    <= rx_data;
                                hold_full <= 1'b1;
                            end
                        end
                    end else if (last_byte) begin
                        // Frame complete; nothing may carry over into the next one.
                        state      <= START;
                        core_start <= 1'b1;
                        ram_we     <= 1'b0;
                        ram_d      <= 1'b0;
                        byte_cnt   <= byte_cnt_inc;
                        hold_full  <= 1'b0;
                        if (rx_rdy || hold_full) begin
                            err_ovr <= 1'b1;
                        end
                    end else if (hold_full || rx_rdy) begin
                        // Next byte follows back-to-back, held byte first.
                        ram_we    <= 1'b1;
                        ram_d     <= load_byte[0];
                        ram_addr  <= base_addr(byte_cnt_inc);
                        shift_q   <= {1'b0, load_byte[7:1]};
                        bit_cnt   <= '0;
                        byte_cnt  <= byte_cnt_inc;
                        hold_full <= hold_full && rx_rdy;
                        if (hold_full && rx_rdy) begin
                            hold_q <= rx_data;
                        end
                    end else begin
                        state    <= RX_WAIT;
                        busy     <= 1'b0;
                        ram_we   <= 1'b0;
                        ram_d    <= 1'b0;
                        byte_cnt <= byte_cnt_inc;
                    end
                end

                START: begin
                    state    <= COMPUTE;
                    byte_cnt <= '0;
`ifdef SNN_SEQ_CTRL_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                end

                COMPUTE: begin
                    if (core_done) begin
                        state   <= TX_WAIT;
                        result  <= core_digit;
                        tx_data <= to_ascii(core_digit);
`ifdef SNN_SEQ_CTRL_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= TX_WAIT;
                        err_tmo <= 1'b1;
                        result  <= 4'hF;
                        tx_data <= 8'h3F;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end

                TX_WAIT: begin
                    if (tx_rdy) begin
                        state    <= TX_SEND;
                        tx_start <= 1'b1;
                    end
                end

                TX_SEND: begin
                    state <= RX_WAIT;
                    busy  <= 1'b0;
                end

                default: begin
                    state  <= RX_WAIT;
                    busy   <= 1'b0;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
